// File: rtl/zipdma_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | zipdma_sched : round-robin scheduler sharing one ZipDMA engine among NCH |
// | requesters with per-channel abort and zero-length short-circuit. Rev 1.0 |
// +--------------------------------------------------------------------------+
module zipdma_sched #(
  parameter int NCH           = 4,
  parameter int ADDRESS_WIDTH = 30,
  parameter int LGDMALENGTH   = ADDRESS_WIDTH
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [NCH-1:0]               i_req,
  input  logic [NCH*ADDRESS_WIDTH-1:0] i_src,
  input  logic [NCH*ADDRESS_WIDTH-1:0] i_dst,
  input  logic [NCH*LGDMALENGTH-1:0]   i_len,
  input  logic [NCH-1:0]               i_abort,
  output logic [NCH-1:0]               o_start,
  output logic [NCH-1:0]               o_done,
  output logic [NCH-1:0]               o_err,
  output logic [$clog2(NCH)-1:0]       o_active,
  output logic                         o_busy,
  output logic                         o_dma_request,
  output logic                         o_dma_abort,
  input  logic                         i_dma_busy,
  input  logic                         i_dma_err,
  output logic [ADDRESS_WIDTH-1:0]     o_src_addr,
  output logic [ADDRESS_WIDTH-1:0]     o_dst_addr,
  output logic [LGDMALENGTH-1:0]       o_length
);
  localparam int CW = $clog2(NCH);
  localparam int AW = ADDRESS_WIDTH;
  localparam int LW = LGDMALENGTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_RUN    = 3'd2,
    S_ABORT  = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ptr_q, ptr_d, active_q, active_d;
  logic [AW-1:0]   src_q, src_d, dst_q, dst_d;
  logic [LW-1:0]   len_q, len_d;
  logic [NCH-1:0]  start_q, start_d, done_q, done_d, err_q, err_d;
  logic            busy_q, busy_d, dabort_q, dabort_d, sticky_q, sticky_d;

  logic            gnt_found;
  logic [CW-1:0]   gnt_idx, cand;
  logic [AW-1:0]   sel_src, sel_dst;
  logic [LW-1:0]   sel_len;
  logic            abort_hit, dma_req;

  // ptr_q is the first channel to consider; scanning down leaves the nearest hit
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      cand = CW'((int'(ptr_q) + i) % NCH);
      if (i_req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_src = '0;
    sel_dst = '0;
    sel_len = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt_idx == CW'(k)) begin
        sel_src = i_src[k*AW +: AW];
        sel_dst = i_dst[k*AW +: AW];
        sel_len = i_len[k*LW +: LW];
      end
    end
  end

  assign abort_hit = i_abort[active_q];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    active_d = active_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    busy_d   = busy_q;
    sticky_d = sticky_q;
    start_d  = '0;
    done_d   = '0;
    err_d    = '0;
    dabort_d = 1'b0;
    dma_req  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found && !i_dma_busy) begin
          start_d[gnt_idx] = 1'b1;
          active_d = gnt_idx;
          src_d    = sel_src;
          dst_d    = sel_dst;
          len_d    = sel_len;
          busy_d   = 1'b1;
          sticky_d = 1'b0;
          state_d  = (sel_len == '0) ? S_REPORT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort_hit) begin
          dabort_d = 1'b1;
          sticky_d = 1'b1;
          state_d  = S_ABORT;
        end else if (i_dma_busy) begin
          state_d = S_RUN;
        end else begin
          dma_req = 1'b1;
        end
      end
      S_RUN: begin
        sticky_d = sticky_q | i_dma_err;
        // abort takes precedence over a completion seen in the same cycle
        if (abort_hit) begin
          dabort_d = 1'b1;
          sticky_d = 1'b1;
          state_d  = S_ABORT;
        end else if (!i_dma_busy) begin
          state_d = S_REPORT;
        end
      end
      S_ABORT: begin
        if (!i_dma_busy) state_d = S_REPORT;
      end
      S_REPORT: begin
        done_d[active_q] = 1'b1;
        err_d[active_q]  = sticky_q;
        sticky_d = 1'b0;
        ptr_d    = (active_q == CW'(NCH-1)) ? '0 : active_q + 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      active_q <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      busy_q   <= 1'b0;
      sticky_q <= 1'b0;
      start_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      dabort_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      active_q <= active_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      busy_q   <= busy_d;
      sticky_q <= sticky_d;
      start_q  <= start_d;
      done_q   <= done_d;
      err_q    <= err_d;
      dabort_q <= dabort_d;
    end
  end

  assign o_start       = start_q;
  assign o_done        = done_q;
  assign o_err         = err_q;
  assign o_active      = active_q;
  assign o_busy        = busy_q;
  assign o_dma_request = dma_req;
  assign o_dma_abort   = dabort_q;
  assign o_src_addr    = src_q;
  assign o_dst_addr    = dst_q;
  assign o_length      = len_q;

endmodule
`default_nettype wire

// File: tb/tb_zipdma_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_zipdma_sched : bench for zipdma_sched with a behavioural engine and   |
// | round-robin reference model. Rev 1.0                                    |
// +--------------------------------------------------------------------------+
module tb_zipdma_sched;
  localparam int NCH = 4;
  localparam int AW  = 30;
  localparam int LW  = 30;

  logic              clk = 1'b0;
  logic              i_reset;
  logic [NCH-1:0]    i_req, i_abort;
  logic [NCH*AW-1:0] i_src, i_dst;
  logic [NCH*LW-1:0] i_len;
  logic [NCH-1:0]    o_start, o_done, o_err;
  logic [1:0]        o_active;
  logic              o_busy, o_dma_request, o_dma_abort;
  logic              i_dma_busy, i_dma_err;
  logic [AW-1:0]     o_src_addr, o_dst_addr;
  logic [LW-1:0]     o_length;

  int errors = 0;
  int checks = 0;
  int req_cnt = 0, abort_cnt = 0, done_cnt = 0;
  int eng_len = 4;
  int eng_err_at = -1;

  logic [AW-1:0] m_src [NCH];
  logic [AW-1:0] m_dst [NCH];
  logic [LW-1:0] m_len [NCH];
  int mdl_ptr = 0;

  always #5 clk = ~clk;

  zipdma_sched #(.NCH(NCH), .ADDRESS_WIDTH(AW), .LGDMALENGTH(LW)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .i_src(i_src), .i_dst(i_dst),
    .i_len(i_len), .i_abort(i_abort), .o_start(o_start), .o_done(o_done),
    .o_err(o_err), .o_active(o_active), .o_busy(o_busy),
    .o_dma_request(o_dma_request), .o_dma_abort(o_dma_abort),
    .i_dma_busy(i_dma_busy), .i_dma_err(i_dma_err), .o_src_addr(o_src_addr),
    .o_dst_addr(o_dst_addr), .o_length(o_length)
  );

  // Engine: accepts a request, stays busy eng_len cycles, may flag an error, stops on abort
  initial begin
    i_dma_busy = 1'b0;
    i_dma_err  = 1'b0;
    forever begin
      @(posedge clk); #3;
      if (o_dma_request) begin
        i_dma_busy = 1'b1;
        for (int k = 0; k < eng_len; k++) begin
          i_dma_err = (k == eng_err_at);
          @(posedge clk); #3;
          i_dma_err = 1'b0;
          if (o_dma_abort) break;
        end
        i_dma_busy = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #2;
      if (o_dma_request) req_cnt++;
      if (o_dma_abort)   abort_cnt++;
      if (o_done != '0)  done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int first_set(input logic [NCH-1:0] v);
    first_set = -1;
    for (int k = NCH-1; k >= 0; k--) if (((v >> k) & 1) != 0) first_set = k;
  endfunction

  // Reference arbitration: first requester at or after the pointer, wrapping
  function automatic int rr_pick(input logic [NCH-1:0] m, input int p);
    for (int s = 0; s < NCH; s++)
      if (((m >> ((p + s) % NCH)) & 1) != 0) return (p + s) % NCH;
    return -1;
  endfunction

  task automatic set_ch(input int ch, input logic [AW-1:0] s, input logic [AW-1:0] d,
                        input logic [LW-1:0] l);
    i_src[ch*AW +: AW] = s;
    i_dst[ch*AW +: AW] = d;
    i_len[ch*LW +: LW] = l;
    m_src[ch] = s;
    m_dst[ch] = d;
    m_len[ch] = l;
  endtask

  task automatic wait_start(output int ch, output bit to);
    to = 1'b1;
    ch = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (o_start != '0) begin
        to = 1'b0;
        ch = first_set(o_start);
        break;
      end
    end
  endtask

  task automatic wait_done(output int ch, output bit err, output bit to);
    to  = 1'b1;
    ch  = -1;
    err = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (o_done != '0) begin
        to  = 1'b0;
        ch  = first_set(o_done);
        err = ((o_err >> ch) & 1) != 0;
        break;
      end
    end
  endtask

  task automatic wait_busy(output bit to);
    to = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (i_dma_busy) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic pulse_reset;
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    mdl_ptr = 0;
  endtask

  task automatic test_reset;
    i_reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_start, o_done, o_err, o_active, o_busy, o_dma_request, o_dma_abort,
         o_src_addr, o_dst_addr, o_length} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: start=%b done=%b err=%b active=%0d busy=%b req=%b abort=%b src=%h dst=%h len=%h, want all 0",
               o_start, o_done, o_err, o_active, o_busy, o_dma_request, o_dma_abort,
               o_src_addr, o_dst_addr, o_length);
    end
    i_reset = 1'b0;
    mdl_ptr = 0;
  endtask

  task automatic test_single;
    int ch, r0;
    bit to, err;
    eng_len = 10;
    eng_err_at = -1;
    r0 = req_cnt;
    set_ch(2, 30'h100, 30'h200, 30'd64);
    i_req = 4'b0100;
    wait_start(ch, to);
    checks++;
    if (to || ch != 2) begin
      errors++;
      $display("FAIL single_start: got ch=%0d timeout=%0b, want ch=2", ch, to);
    end
    checks++;
    if (o_src_addr !== 30'h100 || o_dst_addr !== 30'h200 || o_length !== 30'd64) begin
      errors++;
      $display("FAIL single_latch: got %h/%h/%0d, want 100/200/64", o_src_addr, o_dst_addr, o_length);
    end
    checks++;
    if (o_busy !== 1'b1 || o_active !== 2'd2) begin
      errors++;
      $display("FAIL single_owner: got busy=%b active=%0d, want 1/2", o_busy, o_active);
    end
    i_req = '0;
    wait_done(ch, err, to);
    checks++;
    if (to || ch != 2 || err !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got ch=%0d err=%0b timeout=%0b, want ch=2 err=0", ch, err, to);
    end
    checks++;
    if (req_cnt - r0 != 1) begin
      errors++;
      $display("FAIL single_request: got %0d request cycles, want 1", req_cnt - r0);
    end
    checks++;
    if (o_src_addr !== 30'h100 || o_dst_addr !== 30'h200 || o_length !== 30'd64 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_hold: got %h/%h/%0d busy=%b, want 100/200/64 busy=0",
               o_src_addr, o_dst_addr, o_length, o_busy);
    end
    mdl_ptr = 3;
  endtask

  task automatic test_zero_len;
    int ch, r0;
    bit to;
    r0 = req_cnt;
    set_ch(1, 30'h3A5, 30'h1C0, 30'd0);
    i_req = 4'b0010;
    wait_start(ch, to);
    checks++;
    if (to || ch != 1) begin
      errors++;
      $display("FAIL zero_start: got ch=%0d timeout=%0b, want ch=1", ch, to);
    end
    i_req = '0;
    @(negedge clk);
    checks++;
    if (o_done !== 4'b0010 || o_err !== 4'b0000) begin
      errors++;
      $display("FAIL zero_done: got done=%b err=%b one cycle after start, want 0010/0000", o_done, o_err);
    end
    checks++;
    if (req_cnt != r0) begin
      errors++;
      $display("FAIL zero_norequest: got %0d request cycles, want 0", req_cnt - r0);
    end
  endtask

  task automatic test_round_robin;
    int ch, exp, prev;
    bit to, err;
    pulse_reset();
    for (int k = 0; k < NCH; k++) set_ch(k, AW'(32'h1000 * (k + 1)), AW'(32'h8000 + k), LW'(16 + k));
    eng_len = 5;
    eng_err_at = -1;
    prev = -1;
    i_req = 4'hF;
    for (int n = 0; n < 5; n++) begin
      exp = rr_pick(4'hF, mdl_ptr);
      wait_start(ch, to);
      checks++;
      if (to || ch != exp || ch == prev) begin
        errors++;
        $display("FAIL rr_grant%0d: got ch=%0d timeout=%0b, want ch=%0d", n, ch, to, exp);
      end
      wait_done(ch, err, to);
      if (n == 4) i_req = '0;
      checks++;
      if (to || ch != exp || err !== 1'b0) begin
        errors++;
        $display("FAIL rr_done%0d: got ch=%0d err=%0b, want ch=%0d err=0", n, ch, err, exp);
      end
      prev = exp;
      mdl_ptr = (exp + 1) % NCH;
    end
  endtask

  task automatic test_error;
    int ch;
    bit to, err;
    set_ch(0, 30'h40, 30'h80, 30'd32);
    eng_len = 6;
    eng_err_at = 3;
    i_req = 4'b0001;
    wait_start(ch, to);
    i_req = '0;
    wait_done(ch, err, to);
    checks++;
    if (to || ch != 0 || err !== 1'b1) begin
      errors++;
      $display("FAIL error_flag: got ch=%0d err=%0b timeout=%0b, want ch=0 err=1", ch, err, to);
    end
    eng_err_at = -1;
    set_ch(3, 30'h44, 30'h88, 30'd8);
    i_req = 4'b1000;
    wait_start(ch, to);
    i_req = '0;
    wait_done(ch, err, to);
    checks++;
    if (to || ch != 3 || err !== 1'b0) begin
      errors++;
      $display("FAIL error_cleared: got ch=%0d err=%0b timeout=%0b, want ch=3 err=0", ch, err, to);
    end
  endtask

  task automatic test_abort;
    int ch, a0;
    bit to, err;
    eng_len = 30;
    eng_err_at = -1;
    set_ch(3, 30'h300, 30'h600, 30'd100);
    set_ch(0, 30'h010, 30'h020, 30'd4);
    i_req = 4'b1000;
    wait_start(ch, to);
    i_req = 4'b0001;
    a0 = abort_cnt;
    wait_busy(to);
    repeat (2) @(negedge clk);
    i_abort = 4'b0001;
    @(negedge clk);
    i_abort = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (to || abort_cnt != a0 || o_busy !== 1'b1 || o_active !== 2'd3 || o_done !== '0) begin
      errors++;
      $display("FAIL abort_foreign: got aborts=%0d busy=%b active=%0d done=%b, want 0/1/3/0000",
               abort_cnt - a0, o_busy, o_active, o_done);
    end
    i_abort = 4'b1000;
    @(negedge clk);
    i_abort = '0;
    wait_done(ch, err, to);
    checks++;
    if (to || ch != 3 || err !== 1'b1) begin
      errors++;
      $display("FAIL abort_done: got ch=%0d err=%0b timeout=%0b, want ch=3 err=1", ch, err, to);
    end
    checks++;
    if (abort_cnt - a0 != 1) begin
      errors++;
      $display("FAIL abort_pulse: got %0d abort cycles, want 1", abort_cnt - a0);
    end
    wait_start(ch, to);
    i_req = '0;
    checks++;
    if (to || ch != 0) begin
      errors++;
      $display("FAIL abort_pending: got ch=%0d timeout=%0b, want ch=0", ch, to);
    end
    wait_done(ch, err, to);
    checks++;
    if (to || ch != 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL abort_next: got ch=%0d err=%0b, want ch=0 err=0", ch, err);
    end
  endtask

  task automatic test_reset_mid;
    int ch, d0;
    bit to, err;
    eng_len = 20;
    set_ch(1, 30'h111, 30'h222, 30'd50);
    i_req = 4'b0010;
    wait_start(ch, to);
    i_req = '0;
    wait_busy(to);
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    i_reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_start, o_done, o_err, o_active, o_busy, o_dma_request, o_dma_abort,
         o_src_addr, o_dst_addr, o_length} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: busy=%b active=%0d req=%b abort=%b src=%h, want all 0",
               o_busy, o_active, o_dma_request, o_dma_abort, o_src_addr);
    end
    i_reset = 1'b0;
    mdl_ptr = 0;
    for (int c = 0; c < 60 && i_dma_busy; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != d0 || i_dma_busy) begin
      errors++;
      $display("FAIL midreset_nodone: got %0d done pulses engine_busy=%b, want 0/0", done_cnt - d0, i_dma_busy);
    end
    eng_len = 3;
    for (int k = 0; k < NCH; k++) set_ch(k, AW'(k + 5), AW'(k + 9), LW'(k + 1));
    i_req = 4'hF;
    wait_start(ch, to);
    i_req = '0;
    checks++;
    if (to || ch != 0) begin
      errors++;
      $display("FAIL midreset_regrant: got ch=%0d timeout=%0b, want ch=0", ch, to);
    end
    wait_done(ch, err, to);
    mdl_ptr = 1;
  endtask

  task automatic test_random;
    logic [NCH-1:0] pending, add;
    int ch, exp, r0;
    bit to, err, inj, exp_err;
    pulse_reset();
    pending = '0;
    for (int n = 0; n < 40; n++) begin
      add = NCH'($urandom_range(0, (1 << NCH) - 1)) & ~pending;
      if (pending == '0 && add == '0) add = NCH'(1 << $urandom_range(0, NCH-1));
      for (int k = 0; k < NCH; k++)
        if (((add >> k) & 1) != 0)
          set_ch(k, AW'($urandom), AW'($urandom),
                 ($urandom_range(0, 3) == 0) ? '0 : LW'($urandom_range(1, 4096)));
      pending = pending | add;
      exp = rr_pick(pending, mdl_ptr);
      eng_len = $urandom_range(2, 8);
      inj = ($urandom_range(0, 2) == 0);
      eng_err_at = inj ? $urandom_range(1, eng_len - 1) : -1;
      exp_err = inj && (m_len[exp] != '0);
      r0 = req_cnt;
      i_req = pending;
      wait_start(ch, to);
      pending = pending & ~(NCH'(1) << exp);
      i_req = pending;
      checks++;
      if (to || ch != exp) begin
        errors++;
        $display("FAIL rand%0d_grant: got ch=%0d timeout=%0b, want ch=%0d", n, ch, to, exp);
      end
      checks++;
      if (o_src_addr !== m_src[exp] || o_dst_addr !== m_dst[exp] || o_length !== m_len[exp]) begin
        errors++;
        $display("FAIL rand%0d_latch: got %h/%h/%h, want %h/%h/%h", n, o_src_addr, o_dst_addr,
                 o_length, m_src[exp], m_dst[exp], m_len[exp]);
      end
      wait_done(ch, err, to);
      checks++;
      if (to || ch != exp || err !== exp_err) begin
        errors++;
        $display("FAIL rand%0d_done: got ch=%0d err=%0b timeout=%0b, want ch=%0d err=%0b",
                 n, ch, err, to, exp, exp_err);
      end
      checks++;
      if ((req_cnt - r0) != ((m_len[exp] != '0) ? 1 : 0)) begin
        errors++;
        $display("FAIL rand%0d_reqcount: got %0d request cycles for len=%0d", n, req_cnt - r0, m_len[exp]);
      end
      mdl_ptr = (exp + 1) % NCH;
    end
    i_req = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    i_reset = 1'b1;
    i_req   = '0;
    i_abort = '0;
    i_src   = '0;
    i_dst   = '0;
    i_len   = '0;
    test_reset();
    test_single();
    test_zero_len();
    test_round_robin();
    test_error();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
